// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, supported bit
// periods and the 2-of-3 majority helper used by the bit sampler.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic prescale_supported(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Oversampling bit detector: captures RX_IN at the three edge counts around the
// bit centre and presents their 2-of-3 majority.
module uart_rx_data_sampling (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_in,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] prescale,
  output logic       sampled_bit
);
  import uart_rx_pkg::*;

  logic [5:0] half;
  logic [2:0] samples;

  assign half = prescale >> 1;

  // The vote is stable from edge count half+2 until the next bit overwrites it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samples <= '0;
    end else begin
      if (edge_cnt == half - 6'd1) samples[0] <= rx_in;
      if (edge_cnt == half)        samples[1] <= rx_in;
      if (edge_cnt == half + 6'd1) samples[2] <= rx_in;
    end
  end

  assign sampled_bit = majority3(samples[0], samples[1], samples[2]);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start/data/parity/stop framing with per-frame latched bit
// period and parity mode, registered single-cycle result pulses.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);
  import uart_rx_pkg::*;

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_t             state;
  logic [5:0]            edge_cnt;
  logic [5:0]            prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_err_flag;
  logic                  sampled_bit;
  logic                  bit_end;
  logic                  expected_par;

  uart_rx_data_sampling u_sampling (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (RX_IN),
    .edge_cnt    (edge_cnt),
    .prescale    (prescale_q),
    .sampled_bit (sampled_bit)
  );

  assign bit_end      = (edge_cnt == prescale_q - 6'd1);
  assign expected_par = (^shift_reg) ^ par_typ_q;

  // NOTE: every register here, shift register and P_DATA included, is cleared by
  // the async reset so an abandoned frame leaves no trace; all state updates use
  // non-blocking assignments so the case arms see pre-edge values only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      prescale_q   <= PRESCALE_8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_err_flag <= 1'b0;
      P_DATA       <= '0;
      DATA_VALID   <= 1'b0;
      PAR_ERR      <= 1'b0;
      STP_ERR      <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
      end

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            // The detection cycle is edge 0 of the start bit, so counting resumes at 1.
            state        <= START;
            edge_cnt     <= 6'd1;
            prescale_q   <= prescale_supported(PRESCALE) ? PRESCALE : PRESCALE_16;
            par_en_q     <= PAR_EN;
            par_typ_q    <= PAR_TYP;
            bit_cnt      <= '0;
            par_err_flag <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            state <= sampled_bit ? IDLE : DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            par_err_flag <= (sampled_bit != expected_par);
            state        <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            STP_ERR <= !sampled_bit;
            PAR_ERR <= par_err_flag;
            if (sampled_bit && !par_err_flag) begin
              DATA_VALID <= 1'b1;
              P_DATA     <= shift_reg;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized scoreboard bench for uart_rx_deserializer: a frame-level model
// predicts each result pulse and its cycle; a monitor checks what the DUT emits.
module tb_uart_rx_deserializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  uart_rx_deserializer #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned cyc;
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  last_good = 8'h00;
  logic [7:0]  pdata_hold = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: consumes one prediction per result pulse, flags late or missing ones.
  always @(negedge CLK) begin
    if (!RST) begin
      pdata_hold = 8'h00;
    end else begin
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        check("missing_pulse", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      if (DATA_VALID || PAR_ERR || STP_ERR) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("data_valid", DATA_VALID, e.dv);
          check("par_err", PAR_ERR, e.pe);
          check("stp_err", STP_ERR, e.se);
          check("p_data", P_DATA, e.data);
          pdata_hold = e.data;
        end
      end else if (P_DATA !== pdata_hold) begin
        check("p_data_hold", P_DATA, pdata_hold);
        pdata_hold = P_DATA;
      end
    end
  end

  function automatic logic [5:0] rand_prescale();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit bad_par, input bit bad_stop);
    logic bits[$];
    logic par_bit;
    exp_t e;
    // Even parity makes the total count of ones even, odd makes it odd.
    par_bit = (($countones(d) % 2) == 1) ^ pt;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(par_bit ^ bad_par);
    bits.push_back(!bad_stop);

    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    e.cyc  = cyc + bits.size() * p;
    e.pe   = pe && bad_par;
    e.se   = bad_stop;
    e.dv   = !e.pe && !e.se;
    if (e.dv) last_good = d;
    e.data = last_good;
    sb.push_back(e);

    foreach (bits[i]) begin
      RX_IN = bits[i];
      if (i == 1) begin
        // Config changes mid-frame must not disturb the frame in flight.
        PRESCALE = rand_prescale();
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
      end
      repeat (p) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic send_glitch(input int p, input int g);
    PRESCALE = 6'(p);
    RX_IN = 1'b0;
    repeat (g) begin
      @(posedge CLK);
      #1;
    end
    idle(p - g);
  endtask

  task automatic send_aborted(input logic [7:0] d, input int p);
    PRESCALE = 6'(p);
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (p) begin
      @(posedge CLK);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      RX_IN = d[i];
      repeat ((i < 4) ? p : p / 2) begin
        @(posedge CLK);
        #1;
      end
    end
    #2;
    RST = 1'b0;
    #1;
    check("abort_data_valid", DATA_VALID, 1'b0);
    check("abort_par_err", PAR_ERR, 1'b0);
    check("abort_stp_err", STP_ERR, 1'b0);
    check("abort_p_data", P_DATA, 8'h00);
    last_good = 8'h00;
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(2);
  endtask

  initial begin
    #2;
    check("reset_p_data", P_DATA, 8'h00);
    check("reset_data_valid", DATA_VALID, 1'b0);
    check("reset_par_err", PAR_ERR, 1'b0);
    check("reset_stp_err", STP_ERR, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(3);

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send_glitch(8, 2);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    send_frame(8'h81, 16, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(2);
    send_aborted(8'hC3, 16);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int p;
      bit pe;
      p  = int'(rand_prescale());
      pe = 1'($urandom);
      if ($urandom_range(0, 9) == 0) send_glitch(p, $urandom_range(1, p / 2 - 1));
      send_frame(8'($urandom), p, pe, 1'($urandom),
                 pe && ($urandom_range(0, 5) == 0), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end

    idle(40);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RX_IN  input  1  serial line; idle high; already synchronous to CLK.
REQ-005 SHALL have port PRESCALE  input  6  CLK cycles per bit; supported values 8, 16, 32 only.
REQ-006 SHALL have port PAR_EN  input  1  parity bit present when 1.
REQ-007 SHALL have port PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last good received word.
REQ-009 SHALL have port DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 SHALL have port PAR_ERR  output  1  one-cycle pulse on parity mismatch.
REQ-011 SHALL have port STP_ERR  output  1  one-cycle pulse on a stop bit sampled as 0.

Function
REQ-012 SHALL receive frames in this order: start (0), DATA_WIDTH data bits LSB first, parity bit if PAR_EN, stop (1); each bit lasts PRESCALE cycles.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP; no other reachable states.
REQ-014 SHALL, in IDLE, move to START when RX_IN==0 is sampled; that cycle is frame cycle 0 and edge count 0.
REQ-015 SHALL latch PRESCALE, PAR_EN and PAR_TYP at frame cycle 0; input changes mid-frame SHALL NOT affect the current frame.
REQ-016 SHALL run an edge counter 0..PRESCALE-1 per bit, wrapping to 0 and advancing a bit counter on wrap.
REQ-017 SHALL sample RX_IN at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1; the bit value is the 2-of-3 majority, valid from edge count PRESCALE/2+2.
REQ-018 SHALL handle a start bit majority of 1 (glitch) by returning to IDLE at the end of START, with no output pulse.
REQ-019 SHALL shift data majority bits into a shift register LSB first; after bit DATA_WIDTH-1 it goes to PARITY if PAR_EN, else to STOP.
REQ-020 SHALL compute expected parity as XOR of the data bits for even parity, and its inverse for odd; a received parity that differs sets an internal error flag.
REQ-021 SHALL, at STOP edge count PRESCALE-1, return to IDLE, with registered outputs taking effect next cycle:
- stop=1 and no parity error: DATA_VALID=1 and P_DATA=shift register.
- parity error: PAR_ERR=1.
- stop=0: STP_ERR=1.
- PAR_ERR and STP_ERR may pulse in the same cycle.
- On any error, DATA_VALID=0 and P_DATA is held.
REQ-022 SHALL pulse DATA_VALID in frame cycle (DATA_WIDTH+2+PAR_EN)*PRESCALE.
REQ-023 SHALL hold DATA_VALID, PAR_ERR and STP_ERR at 0 in every other cycle; P_DATA holds its value between pulses.
REQ-024 SHALL accept back-to-back frames with zero idle bits, starting detection in the IDLE cycle after STOP (at most 1 CLK of extra skew).

Reset
REQ-025 SHALL, when RST is low, force the state to IDLE, the edge and bit counters to 0, the shift register to 0, the parity flag to 0, P_DATA to 0, and DATA_VALID, PAR_ERR and STP_ERR to 0, immediately and independent of CLK.
REQ-026 SHALL abandon a frame in progress at reset with no output pulse; after RST deasserts, the next falling RX_IN in IDLE starts a new frame.

Structure
REQ-027 SHALL place the FSM state encoding and the supported PRESCALE constants (8, 16, 32) in shared package uart_rx_pkg.
REQ-028 SHALL implement the sampling and majority voter of REQ-017 in sub-module uart_rx_data_sampling, driven by the edge count and latched PRESCALE.
REQ-029 SHALL keep the FSM, counters, shift register, parity check and output registers in uart_rx_deserializer.

Verification
REQ-030 SHALL cover: PRESCALE=8, PAR_EN=0, byte 0xA5 -> DATA_VALID pulse in frame cycle 80, P_DATA=0xA5, no errors.
REQ-031 SHALL cover: PRESCALE=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0 -> DATA_VALID in cycle 176, P_DATA=0x3C.
REQ-032 SHALL cover: as REQ-031 with parity bit 1 -> PAR_ERR pulse in cycle 176, DATA_VALID=0, P_DATA unchanged.
REQ-033 SHALL cover: PRESCALE=8, RX_IN low for 2 cycles, then high -> return to IDLE, no pulses; a following frame 0x5A is received correctly.
REQ-034 SHALL cover: PRESCALE=32, byte 0xFF with stop bit 0 -> STP_ERR pulse in cycle 320, DATA_VALID=0.
REQ-035 SHALL cover: RST low during DATA bit 4 -> all outputs 0 at once; the next frame 0x0F gives DATA_VALID with P_DATA=0x0F.
